// File: rtl/rom_access_arbiter.sv
// Round-robin arbiter sharing the single ROM read port between fetch (port 0) and load (port 1).
// One access in flight; sequences ROM latency, range-checks addresses, returns data on valid/ready.
module rom_access_arbiter #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned ROM_DEPTH   = 256,
  parameter int unsigned ROM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr0,
  input  logic [ADDR_WIDTH-1:0] req_addr1,
  output logic [1:0]            rsp_valid,
  input  logic [1:0]            rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_error,
  output logic                  rom_en,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  input  logic                  rom_error
);

  localparam int unsigned CNT_W = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic                  last_grant;
  logic                  gnt_id;
  logic [CNT_W-1:0]      cnt;

  logic                  grant_c;
  logic [ADDR_WIDTH-1:0] addr_sel_c;
  logic                  oor_c;
  logic                  last_cnt_c;

  // Round-robin pick: a lone requester wins, a tie goes to the port not served last.
  always_comb begin
    grant_c    = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
    addr_sel_c = grant_c ? req_addr1 : req_addr0;
    oor_c      = (32'(addr_sel_c) >= ROM_DEPTH);
    last_cnt_c = (cnt == CNT_W'(ROM_LATENCY - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 2'b00;
    case (state)
      ST_IDLE: begin
        if (|req_valid) begin
          req_ready = {grant_c, ~grant_c};
          state_nxt = oor_c ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (last_cnt_c) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready[gnt_id]) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath and registered outputs; reset discards any in-flight access.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid  <= 2'b00;
      rsp_data   <= '0;
      rsp_error  <= 1'b0;
      rom_en     <= 1'b0;
      rom_addr   <= '0;
      last_grant <= 1'b1;
      gnt_id     <= 1'b0;
      cnt        <= '0;
    end else begin
      rom_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|req_valid) begin
            gnt_id     <= grant_c;
            last_grant <= grant_c;
            cnt        <= '0;
            if (oor_c) begin
              rsp_data  <= '0;
              rsp_error <= 1'b1;
              rsp_valid <= {grant_c, ~grant_c};
            end else begin
              rom_addr <= addr_sel_c;
              rom_en   <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          cnt <= cnt + CNT_W'(1);
          if (last_cnt_c) begin
            rsp_data  <= rom_data;
            rsp_error <= rom_error;
            rsp_valid <= {gnt_id, ~gnt_id};
          end
        end
        ST_RESP: begin
          if (rsp_ready[gnt_id]) rsp_valid <= 2'b00;
        end
        default: rsp_valid <= 2'b00;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_access_arbiter.sv
// Randomized bench for rom_access_arbiter against a transaction-timeline reference model.
module tb_rom_access_arbiter;

  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 200;
  localparam int unsigned LAT   = 3;
  localparam int          NCYC  = 4000;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [AW-1:0] req_addr0;
  logic [AW-1:0] req_addr1;
  logic [1:0]    rsp_valid;
  logic [1:0]    rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_error;
  logic          rom_en;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic          rom_error;

  rom_access_arbiter #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .ROM_DEPTH  (DEPTH),
    .ROM_LATENCY(LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr0(req_addr0),
    .req_addr1(req_addr1),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_error(rsp_error),
    .rom_en   (rom_en),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .rom_error(rom_error)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [256];
  logic          err [256];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Model: an access is a timeline counted in cycles since its accept edge.
  bit            busy;
  bit            port;
  logic [AW-1:0] maddr;
  bit            moor;
  int            cs;
  bit            lg;
  logic [AW-1:0] exp_rom_addr;
  logic [1:0]    exp_rdy;
  logic [1:0]    exp_rv;
  int            rst_cnt;
  bit            chk_on;

  function automatic logic [1:0] onehot(input bit p);
    return p ? 2'b10 : 2'b01;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = DW'($urandom);
      err[i] = ($urandom_range(0, 7) == 0);
    end
    mem[8'h10] = 16'hBEEF;
    busy = 0; lg = 1; exp_rom_addr = '0; cs = 0; port = 0; maddr = '0; moor = 0;
    rst_cnt = 3; chk_on = 0;
    rst = 1'b1; req_valid = 2'b00; req_addr0 = '0; req_addr1 = '0;
    rsp_ready = 2'b00; rom_data = '0; rom_error = 1'b0;

    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      if (rst_cnt == 0 && c > 10 && $urandom_range(0, 59) == 0) rst_cnt = 2;
      rst = (rst_cnt > 0);
      if (rst_cnt > 0) rst_cnt--;
      if (!rst && c > 3) chk_on = 1;

      req_valid = 2'($urandom_range(0, 3));
      req_addr0 = AW'($urandom);
      req_addr1 = AW'($urandom);
      if ($urandom_range(0, 3) == 0) req_addr0 = 8'h10;
      if ($urandom_range(0, 5) == 0) req_addr1 = AW'(DEPTH);
      rsp_ready = ($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom_range(0, 3));
      // ROM word is only meaningful in the cycle the design is meant to capture it.
      if (busy && !moor && cs == LAT) begin
        rom_data  = mem[maddr];
        rom_error = err[maddr];
      end else begin
        rom_data  = DW'($urandom);
        rom_error = 1'($urandom);
      end
      #1;

      if (busy) exp_rdy = 2'b00;
      else if (req_valid == 2'b11) exp_rdy = onehot(!lg);
      else exp_rdy = req_valid;
      exp_rv = (busy && cs >= (moor ? 1 : LAT + 1)) ? onehot(port) : 2'b00;

      if (chk_on) begin
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        check("rom_en", 32'(rom_en), 32'(busy && !moor && cs == 1));
        check("rom_addr", 32'(rom_addr), 32'(exp_rom_addr));
        if (exp_rv != 2'b00) begin
          check("rsp_data", 32'(rsp_data), moor ? 32'd0 : 32'(mem[maddr]));
          check("rsp_error", 32'(rsp_error), moor ? 32'd1 : 32'(err[maddr]));
        end
      end

      @(posedge clk);
      if (rst) begin
        busy = 0; lg = 1; exp_rom_addr = '0;
      end else if (busy) begin
        if (exp_rv != 2'b00 && rsp_ready[port]) busy = 0;
        else cs++;
      end else if (exp_rdy != 2'b00) begin
        busy  = 1;
        port  = exp_rdy[1];
        maddr = port ? req_addr1 : req_addr0;
        moor  = (32'(maddr) >= DEPTH);
        cs    = 1;
        lg    = port;
        if (!moor) exp_rom_addr = maddr;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
